// File: rtl/lcd_nibble_receiver_pkg.sv
// Shared types and constants for the HD44780-style 4-bit bus receiver.
// Holds the FSM encoding, command opcodes/masks, DDRAM line bases and wrap limits.
package lcd_nibble_receiver_pkg;

   typedef enum logic [1:0] {
      ST_MODE8    = 2'd0,
      ST_MODE4_HI = 2'd1,
      ST_MODE4_LO = 2'd2
   } lcd_state_e;

   localparam logic [7:0] CMD_CLEAR      = 8'h01;
   localparam logic [7:0] CMD_HOME       = 8'h02;
   localparam logic [7:0] CMD_HOME_MASK  = 8'hFE;
   localparam logic [7:0] CMD_ENTRY      = 8'h04;
   localparam logic [7:0] CMD_ENTRY_MASK = 8'hFC;
   localparam logic [7:0] CMD_SET_ADDR   = 8'h80;

   // High nibble of a function set with DL=0 (switch to 4-bit bus).
   localparam logic [3:0] FSET_DL0_NIB   = 4'h2;

   localparam logic [6:0] LINE0_BASE     = 7'h00;
   localparam logic [6:0] LINE1_BASE     = 7'h40;
   localparam logic [6:0] LINE0_WRAP     = 7'h27;
   localparam logic [6:0] LINE1_WRAP     = 7'h67;

   localparam logic [7:0] BLANK_CHAR     = 8'h20;

   function automatic logic is_cmd(input logic [7:0] b, input logic [7:0] mask,
                                   input logic [7:0] code);
      return (b & mask) == code;
   endfunction

endpackage

// File: rtl/lcd_nibble_receiver_if.sv
// LCD bus plus receiver outputs. The host drives LCDE/LCDRS/LCDRW/LCDDAT (no ready:
// a nibble is transferred on every qualified LCDE fall); the receiver drives the rest.
interface lcd_nibble_receiver_if #(
   parameter int LINE_LEN = 16
);
   import lcd_nibble_receiver_pkg::*;

   localparam int AW = $clog2(2 * LINE_LEN);

   logic          LCDE;
   logic          LCDRS;
   logic          LCDRW;
   logic [3:0]    LCDDAT;
   logic [3:0]    rd_data;
   logic          rd_oe;
   logic          byte_valid;
   logic          byte_rs;
   logic [7:0]    byte_data;
   logic [6:0]    cursor;
   logic          buf_we;
   logic [AW-1:0] buf_addr;
   logic [7:0]    buf_data;
   logic          busy;
   logic          overrun;
   lcd_state_e    dbg_state;

   modport master (
      output LCDE, LCDRS, LCDRW, LCDDAT,
      input  rd_data, rd_oe, byte_valid, byte_rs, byte_data, cursor,
             buf_we, buf_addr, buf_data, busy, overrun, dbg_state
   );

   modport slave (
      input  LCDE, LCDRS, LCDRW, LCDDAT,
      output rd_data, rd_oe, byte_valid, byte_rs, byte_data, cursor,
             buf_we, buf_addr, buf_data, busy, overrun, dbg_state
   );

endinterface

// File: rtl/lcd_nibble_receiver_addr_map.sv
// Combinational DDRAM cursor helper: visible-window lookup into the 2-line shadow
// buffer and next cursor value for increment/decrement with two-line wrap.
module lcd_nibble_receiver_addr_map
   import lcd_nibble_receiver_pkg::*;
#(
   parameter int LINE_LEN = 16
) (
   input  logic [6:0]                      cursor,
   input  logic                            inc,
   output logic                            in_window,
   output logic [$clog2(2*LINE_LEN)-1:0]   buf_idx,
   output logic [6:0]                      next_cursor
);

   localparam int AW = $clog2(2 * LINE_LEN);

   logic [6:0] off0;
   logic [6:0] off1;

   // Offsets wrap below the line base, so a single unsigned compare checks the window.
   assign off0 = cursor - LINE0_BASE;
   assign off1 = cursor - LINE1_BASE;

   always_comb begin
      in_window = 1'b0;
      buf_idx   = '0;
      if (off0 < 7'(LINE_LEN)) begin
         in_window = 1'b1;
         buf_idx   = AW'(off0);
      end else if (off1 < 7'(LINE_LEN)) begin
         in_window = 1'b1;
         buf_idx   = AW'(LINE_LEN) + AW'(off1);
      end
   end

   always_comb begin
      next_cursor = cursor;
      if (inc) begin
         if (cursor == LINE0_WRAP)      next_cursor = LINE1_BASE;
         else if (cursor == LINE1_WRAP) next_cursor = LINE0_BASE;
         else                           next_cursor = cursor + 7'd1;
      end else begin
         if (cursor == LINE0_BASE)      next_cursor = LINE1_WRAP;
         else if (cursor == LINE1_BASE) next_cursor = LINE0_WRAP;
         else                           next_cursor = cursor - 7'd1;
      end
   end

endmodule

// File: rtl/lcd_nibble_receiver.sv
// Responder for an HD44780-style 4-bit LCD bus: syncs the pins, qualifies LCDE falls,
// walks the 8-bit to 4-bit init, rebuilds bytes, tracks the cursor and clears the buffer.
module lcd_nibble_receiver
   import lcd_nibble_receiver_pkg::*;
#(
   parameter int MIN_E_HIGH = 2,
   parameter int LINE_LEN   = 16
) (
   input  logic                  CCLK,
   input  logic                  rst,
   lcd_nibble_receiver_if.slave  bus
);

   localparam int AW = $clog2(2 * LINE_LEN);
   localparam int CW = $clog2(2 * LINE_LEN + 1);
   localparam int HW = $clog2(MIN_E_HIGH + 1);
   localparam logic [CW-1:0] SWEEP_LEN = CW'(2 * LINE_LEN);
   localparam logic [HW-1:0] E_MIN     = HW'(MIN_E_HIGH);

   logic [6:0]    s1_d, s1_q, s2_d, s2_q;
   logic          e_prev_d, e_prev_q;
   logic [HW-1:0] hi_cnt_d, hi_cnt_q;
   lcd_state_e    state_d, state_q;
   logic [3:0]    hi_nib_d, hi_nib_q;
   logic [6:0]    cursor_d, cursor_q;
   logic          inc_d, inc_q;
   logic          busy_d, busy_q;
   logic          overrun_d, overrun_q;
   logic [CW-1:0] cnt_d, cnt_q;
   logic          byte_valid_d, byte_valid_q;
   logic          byte_rs_d, byte_rs_q;
   logic [7:0]    byte_data_d, byte_data_q;
   logic          buf_we_d, buf_we_q;
   logic [AW-1:0] buf_addr_d, buf_addr_q;
   logic [7:0]    buf_data_d, buf_data_q;

   logic          e_s, rs_s, rw_s;
   logic [3:0]    dat_s;
   logic          fall;
   logic          emit;
   logic [7:0]    emit_byte;
   logic          in_window;
   logic [AW-1:0] map_idx;
   logic [6:0]    next_cursor;

   assign e_s   = s2_q[6];
   assign rs_s  = s2_q[5];
   assign rw_s  = s2_q[4];
   assign dat_s = s2_q[3:0];

   lcd_nibble_receiver_addr_map #(.LINE_LEN(LINE_LEN)) u_addr_map (
      .cursor      (cursor_q),
      .inc         (inc_q),
      .in_window   (in_window),
      .buf_idx     (map_idx),
      .next_cursor (next_cursor)
   );

   always_comb begin
      s1_d     = {bus.LCDE, bus.LCDRS, bus.LCDRW, bus.LCDDAT};
      s2_d     = s1_q;
      e_prev_d = e_s;
      hi_cnt_d = '0;
      if (e_s) hi_cnt_d = (hi_cnt_q == E_MIN) ? hi_cnt_q : hi_cnt_q + HW'(1);
   end

   // A fall only counts if synced E was high for at least MIN_E_HIGH cycles.
   assign fall = e_prev_q && !e_s && (hi_cnt_q >= E_MIN);

   always_comb begin
      state_d      = state_q;
      hi_nib_d     = hi_nib_q;
      cursor_d     = cursor_q;
      inc_d        = inc_q;
      busy_d       = busy_q;
      overrun_d    = overrun_q;
      cnt_d        = cnt_q;
      byte_valid_d = 1'b0;
      byte_rs_d    = byte_rs_q;
      byte_data_d  = byte_data_q;
      buf_we_d     = 1'b0;
      buf_addr_d   = buf_addr_q;
      buf_data_d   = buf_data_q;
      emit         = 1'b0;
      emit_byte    = 8'h00;

      if (busy_q) begin
         // Sweep owns the write port; strobes are dropped without touching the phase.
         if (cnt_q == SWEEP_LEN) begin
            busy_d = 1'b0;
         end else begin
            buf_we_d   = 1'b1;
            buf_addr_d = cnt_q[AW-1:0];
            buf_data_d = BLANK_CHAR;
            cnt_d      = cnt_q + CW'(1);
         end
         if (fall) overrun_d = 1'b1;
      end else if (fall) begin
         if (rw_s) begin
            if (state_q == ST_MODE4_HI)      state_d = ST_MODE4_LO;
            else if (state_q == ST_MODE4_LO) state_d = ST_MODE4_HI;
         end else begin
            case (state_q)
               ST_MODE8: begin
                  emit      = 1'b1;
                  emit_byte = {dat_s, 4'h0};
                  if (!rs_s && dat_s == FSET_DL0_NIB) state_d = ST_MODE4_HI;
               end
               ST_MODE4_HI: begin
                  hi_nib_d = dat_s;
                  state_d  = ST_MODE4_LO;
               end
               ST_MODE4_LO: begin
                  emit      = 1'b1;
                  emit_byte = {hi_nib_q, dat_s};
                  state_d   = ST_MODE4_HI;
               end
               default: state_d = ST_MODE8;
            endcase
         end
      end

      if (emit) begin
         byte_valid_d = 1'b1;
         byte_rs_d    = rs_s;
         byte_data_d  = emit_byte;
         if (rs_s) begin
            if (in_window) begin
               buf_we_d   = 1'b1;
               buf_addr_d = map_idx;
               buf_data_d = emit_byte;
            end
            cursor_d = next_cursor;
         end else if (emit_byte == CMD_CLEAR) begin
            // First blank goes out alongside byte_valid; the counter issues the rest.
            cursor_d   = LINE0_BASE;
            inc_d      = 1'b1;
            busy_d     = 1'b1;
            cnt_d      = CW'(1);
            buf_we_d   = 1'b1;
            buf_addr_d = '0;
            buf_data_d = BLANK_CHAR;
         end else if (is_cmd(emit_byte, CMD_HOME_MASK, CMD_HOME)) begin
            cursor_d = LINE0_BASE;
         end else if (is_cmd(emit_byte, CMD_ENTRY_MASK, CMD_ENTRY)) begin
            inc_d = emit_byte[1];
         end else if (is_cmd(emit_byte, CMD_SET_ADDR, CMD_SET_ADDR)) begin
            cursor_d = emit_byte[6:0];
         end
      end
   end

   always_ff @(posedge CCLK) begin
      if (rst) begin
         s1_q         <= '0;
         s2_q         <= '0;
         e_prev_q     <= 1'b0;
         hi_cnt_q     <= '0;
         state_q      <= ST_MODE8;
         hi_nib_q     <= 4'h0;
         cursor_q     <= 7'h00;
         inc_q        <= 1'b1;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
         cnt_q        <= '0;
         byte_valid_q <= 1'b0;
         byte_rs_q    <= 1'b0;
         byte_data_q  <= 8'h00;
         buf_we_q     <= 1'b0;
         buf_addr_q   <= '0;
         buf_data_q   <= 8'h00;
      end else begin
         s1_q         <= s1_d;
         s2_q         <= s2_d;
         e_prev_q     <= e_prev_d;
         hi_cnt_q     <= hi_cnt_d;
         state_q      <= state_d;
         hi_nib_q     <= hi_nib_d;
         cursor_q     <= cursor_d;
         inc_q        <= inc_d;
         busy_q       <= busy_d;
         overrun_q    <= overrun_d;
         cnt_q        <= cnt_d;
         byte_valid_q <= byte_valid_d;
         byte_rs_q    <= byte_rs_d;
         byte_data_q  <= byte_data_d;
         buf_we_q     <= buf_we_d;
         buf_addr_q   <= buf_addr_d;
         buf_data_q   <= buf_data_d;
      end
   end

   assign bus.rd_oe      = rw_s & e_s;
   assign bus.rd_data    = !(rw_s & e_s)              ? 4'h0 :
                           (state_q == ST_MODE4_LO)   ? cursor_q[3:0] :
                                                        {busy_q, cursor_q[6:4]};
   assign bus.byte_valid = byte_valid_q;
   assign bus.byte_rs    = byte_rs_q;
   assign bus.byte_data  = byte_data_q;
   assign bus.cursor     = cursor_q;
   assign bus.buf_we     = buf_we_q;
   assign bus.buf_addr   = buf_addr_q;
   assign bus.buf_data   = buf_data_q;
   assign bus.busy       = busy_q;
   assign bus.overrun    = overrun_q;
   assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// Bench for lcd_nibble_receiver: directed init/command/data/clear steps followed by
// random byte traffic, checked against a byte-level model of the display controller.
module tb_lcd_nibble_receiver;
  import lcd_nibble_receiver_pkg::*;

  logic CCLK = 1'b0;
  logic rst;
  always #5 CCLK = ~CCLK;

  lcd_nibble_receiver_if #(.LINE_LEN(16)) bus ();

  lcd_nibble_receiver #(.MIN_E_HIGH(2), .LINE_LEN(16)) dut (
    .CCLK (CCLK),
    .rst  (rst),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_bv_cyc = -1;
  int fall_cyc = 0;
  int busy_cnt = 0;

  logic [8:0]  act_byte_q[$];
  logic [12:0] act_wr_q[$];
  logic [8:0]  exp_byte_q[$];
  logic [12:0] exp_wr_q[$];
  int act_byte_rd = 0;
  int act_wr_rd = 0;

  // reference model state
  bit         m_mode8;
  bit         m_lo;
  logic [3:0] m_hi;
  logic [6:0] m_cursor;
  bit         m_inc;
  bit         m_overrun;

  logic [6:0] addr_pool [0:9] = '{7'h00, 7'h0F, 7'h10, 7'h27, 7'h3F,
                                  7'h40, 7'h4F, 7'h50, 7'h67, 7'h7F};
  logic [7:0] other_pool [0:4] = '{8'h0C, 8'h10, 8'h18, 8'h28, 8'h38};

  // clock/reset helpers
  always @(posedge CCLK) cyc <= cyc + 1;

  // monitor
  always @(negedge CCLK) begin
    if (!rst) begin
      if (bus.byte_valid) begin
        act_byte_q.push_back({bus.byte_rs, bus.byte_data});
        last_bv_cyc <= cyc;
      end
      if (bus.buf_we) act_wr_q.push_back({bus.buf_addr, bus.buf_data});
      if (bus.busy) busy_cnt <= busy_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: visible window index, -1 when off screen
  function automatic int m_index(input logic [6:0] c);
    if (c < 7'd16) return int'(c);
    if (c >= 7'h40 && c < 7'h50) return 16 + int'(c - 7'h40);
    return -1;
  endfunction

  // model: lines 0x00..0x27 and 0x40..0x67 form one 80-position ring
  function automatic logic [6:0] m_step(input logic [6:0] c, input bit inc);
    int p;
    if (c <= 7'h27 || (c >= 7'h40 && c <= 7'h67)) begin
      p = (c < 7'h40) ? int'(c) : int'(c) - 64 + 40;
      p = inc ? (p + 1) % 80 : (p + 79) % 80;
      return (p < 40) ? 7'(p) : 7'(p - 40 + 64);
    end
    return inc ? c + 7'd1 : c - 7'd1;
  endfunction

  function automatic lcd_state_e m_state();
    if (m_mode8) return ST_MODE8;
    return m_lo ? ST_MODE4_LO : ST_MODE4_HI;
  endfunction

  task automatic m_reset();
    m_mode8 = 1; m_lo = 0; m_hi = 4'h0; m_cursor = 7'h00; m_inc = 1; m_overrun = 0;
  endtask

  task automatic m_byte(input bit rs, input logic [7:0] b);
    int idx;
    exp_byte_q.push_back({rs, b});
    if (rs) begin
      idx = m_index(m_cursor);
      if (idx >= 0) exp_wr_q.push_back({5'(idx), b});
      m_cursor = m_step(m_cursor, m_inc);
    end else if (b == 8'h01) begin
      m_cursor = 7'h00;
      m_inc = 1;
      for (int i = 0; i < 32; i++) exp_wr_q.push_back({5'(i), 8'h20});
    end else if (b == 8'h02 || b == 8'h03) begin
      m_cursor = 7'h00;
    end else if (b >= 8'h04 && b <= 8'h07) begin
      m_inc = b[1];
    end else if (b >= 8'h80) begin
      m_cursor = b[6:0];
    end
  endtask

  task automatic m_nibble(input bit rs, input logic [3:0] d);
    if (m_mode8) begin
      m_byte(rs, {d, 4'h0});
      if (!rs && d == 4'h2) m_mode8 = 0;
    end else if (!m_lo) begin
      m_hi = d;
      m_lo = 1;
    end else begin
      m_byte(rs, {m_hi, d});
      m_lo = 0;
    end
  endtask

  // driver tasks
  task automatic drive_nibble(input bit rs, input bit rw, input logic [3:0] dat, input int hi);
    @(negedge CCLK);
    bus.LCDRS = rs; bus.LCDRW = rw; bus.LCDDAT = dat;
    @(negedge CCLK);
    bus.LCDE = 1'b1;
    repeat (hi) @(negedge CCLK);
    bus.LCDE = 1'b0;
    fall_cyc = cyc;
    repeat (4) @(negedge CCLK);
  endtask

  task automatic wr_nibble(input bit rs, input logic [3:0] dat);
    drive_nibble(rs, 1'b0, dat, 3);
    m_nibble(rs, dat);
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    wr_nibble(rs, b[7:4]);
    wr_nibble(rs, b[3:0]);
  endtask

  task automatic rd_nibble(input string tag);
    logic [3:0] exp_rd;
    exp_rd = m_lo ? m_cursor[3:0] : {1'b0, m_cursor[6:4]};
    @(negedge CCLK);
    bus.LCDRS = 1'b0; bus.LCDRW = 1'b1;
    @(negedge CCLK);
    bus.LCDE = 1'b1;
    repeat (3) @(negedge CCLK);
    check({tag, "_oe"}, bus.rd_oe, 1'b1);
    check({tag, "_data"}, bus.rd_data, exp_rd);
    @(negedge CCLK);
    bus.LCDE = 1'b0;
    repeat (4) @(negedge CCLK);
    bus.LCDRW = 1'b0;
    if (!m_mode8) m_lo = !m_lo;
  endtask

  // scoreboard: compare everything seen since the last call with the model queues
  task automatic check_queues(input string tag);
    int n;
    n = act_byte_q.size() - act_byte_rd;
    check({tag, "_nbytes"}, n, exp_byte_q.size());
    for (int i = 0; i < n && i < exp_byte_q.size(); i++)
      check({tag, "_byte"}, act_byte_q[act_byte_rd + i], exp_byte_q[i]);
    n = act_wr_q.size() - act_wr_rd;
    check({tag, "_nwrites"}, n, exp_wr_q.size());
    for (int i = 0; i < n && i < exp_wr_q.size(); i++)
      check({tag, "_write"}, act_wr_q[act_wr_rd + i], exp_wr_q[i]);
    act_byte_rd = act_byte_q.size();
    act_wr_rd = act_wr_q.size();
    exp_byte_q.delete();
    exp_wr_q.delete();
  endtask

  initial begin
    int b0;
    int waited;
    int op;
    logic [7:0] b;

    rst = 1'b1;
    bus.LCDE = 1'b0; bus.LCDRS = 1'b0; bus.LCDRW = 1'b0; bus.LCDDAT = 4'h0;
    m_reset();
    repeat (4) @(negedge CCLK);
    check("rst_byte_valid", bus.byte_valid, 1'b0);
    check("rst_buf_we", bus.buf_we, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_overrun", bus.overrun, 1'b0);
    check("rst_cursor", bus.cursor, 7'h00);
    check("rst_rd_oe", bus.rd_oe, 1'b0);
    check("rst_state", 32'(bus.dbg_state), 32'(ST_MODE8));
    rst = 1'b0;
    repeat (2) @(negedge CCLK);

    // init sequence 3,3,3,2 then 2,8
    wr_nibble(1'b0, 4'h3);
    check("bv_latency", last_bv_cyc, fall_cyc + 3);
    wr_nibble(1'b0, 4'h3);
    wr_nibble(1'b0, 4'h3);
    check("mode8_after_0x30", 32'(bus.dbg_state), 32'(ST_MODE8));
    wr_nibble(1'b0, 4'h2);
    send_byte(1'b0, 8'h28);
    check_queues("init");
    check("init_state", 32'(bus.dbg_state), 32'(m_state()));

    // set address 0, write 'A'
    send_byte(1'b0, 8'h80);
    send_byte(1'b1, 8'h41);
    check_queues("write_a");
    check("cursor_a", bus.cursor, m_cursor);

    // off-window at 0x27, wrap to line 2
    send_byte(1'b0, 8'hA7);
    send_byte(1'b1, 8'h78);
    check("cursor_x", bus.cursor, m_cursor);
    send_byte(1'b1, 8'h79);
    check_queues("wrap_xy");
    check("cursor_y", bus.cursor, m_cursor);

    // decrement from 0x00 wraps to 0x67
    send_byte(1'b0, 8'h04);
    send_byte(1'b0, 8'h80);
    send_byte(1'b1, 8'h7A);
    check_queues("dec_z");
    check("cursor_z", bus.cursor, m_cursor);
    send_byte(1'b0, 8'h06);

    // reads toggle the nibble phase
    rd_nibble("rd_hi");
    check("rd_hi_state", 32'(bus.dbg_state), 32'(m_state()));
    rd_nibble("rd_lo");
    check("rd_lo_state", 32'(bus.dbg_state), 32'(m_state()));

    // short LCDE pulse is ignored
    drive_nibble(1'b0, 1'b0, 4'h9, 1);
    check("short_state", 32'(bus.dbg_state), 32'(m_state()));
    check_queues("short");

    // clear, then a strobe during the sweep
    b0 = busy_cnt;
    send_byte(1'b0, 8'h01);
    check("clear_busy", bus.busy, 1'b1);
    drive_nibble(1'b0, 1'b0, 4'h5, 3);
    m_overrun = 1;
    repeat (40) @(negedge CCLK);
    check("clear_busy_cycles", busy_cnt - b0, 32);
    check_queues("clear");
    check("clear_overrun", bus.overrun, m_overrun);
    check("clear_state", 32'(bus.dbg_state), 32'(m_state()));
    check("clear_cursor", bus.cursor, m_cursor);

    // random traffic
    for (int k = 0; k < 40; k++) begin
      op = int'($urandom_range(0, 11));
      if (op <= 1)      send_byte(1'b0, {1'b1, addr_pool[$urandom_range(0, 9)]});
      else if (op <= 6) send_byte(1'b1, 8'($urandom_range(32, 126)));
      else if (op == 7) send_byte(1'b0, 8'(4 + $urandom_range(0, 3)));
      else if (op == 8) send_byte(1'b0, 8'(2 + $urandom_range(0, 1)));
      else if (op == 9) send_byte(1'b0, other_pool[$urandom_range(0, 4)]);
      else if (op == 10) begin
        b = 8'h80 | 8'($urandom_range(0, 127));
        send_byte(1'b0, b);
      end else begin
        send_byte(1'b0, 8'h01);
        repeat (40) @(negedge CCLK);
      end
      check_queues("rnd");
      check("rnd_cursor", bus.cursor, m_cursor);
    end
    check("rnd_state", 32'(bus.dbg_state), 32'(m_state()));

    // reset in the middle of a sweep
    send_byte(1'b0, 8'h01);
    waited = 0;
    while (bus.busy !== 1'b1 && waited < 20) begin
      @(negedge CCLK);
      waited++;
    end
    check("sweep_started", bus.busy, 1'b1);
    repeat (5) @(negedge CCLK);
    rst = 1'b1;
    @(negedge CCLK);
    check("rst_sweep_busy", bus.busy, 1'b0);
    check("rst_sweep_we", bus.buf_we, 1'b0);
    check("rst_sweep_state", 32'(bus.dbg_state), 32'(ST_MODE8));
    check("rst_sweep_overrun", bus.overrun, 1'b0);
    rst = 1'b0;
    m_reset();
    act_byte_rd = act_byte_q.size();
    act_wr_rd = act_wr_q.size();
    exp_byte_q.delete();
    exp_wr_q.delete();
    repeat (2) @(negedge CCLK);

    wr_nibble(1'b0, 4'h3);
    check_queues("post_rst");
    check("post_rst_state", 32'(bus.dbg_state), 32'(m_state()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
